fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Sequences the instruction fetch datapath: owns the fetch PC, issues single-outstanding read requests to the instruction memory port, and pushes each returned instruction with its PC into the instruction queue. It also redirects fetch on a backend flush and discards any response that was already in flight when the flush arrived. It sits between the backend flush source, the imem port and the instruction queue.

Parameters:
RESET_PC, 32'h1eceb000, fetch PC loaded on reset
XLEN, 32, address/instruction width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
imem_addr  output  XLEN  request address; always equals the internal pc register
imem_rmask  output  4  4'hf in the issue cycle, else 4'h0
imem_rdata  input  XLEN  instruction data, valid with imem_resp
imem_resp  input  1  one-cycle response for the single outstanding request
iq_full  input  1  instruction queue cannot accept a new request's result
iq_push  output  1  one-cycle push strobe to the instruction queue
iq_instr  output  XLEN  pushed instruction
iq_pc  output  XLEN  PC of the pushed instruction
flush_valid  input  1  redirect request from the backend, one-cycle pulse
flush_pc  input  XLEN  redirect target
busy  output  1  request outstanding (state WAIT or DRAIN)
fetch_count  output  32  count of instructions pushed since reset

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset state:
  - state=IDLE, pc=RESET_PC, fetch_count=0.
  - While rst is high: imem_rmask=0, iq_push=0, busy=0.
- State machine (3 states).
- IDLE:
  - Issue when !flush_valid && !iq_full: imem_rmask=4'hf and imem_addr=pc in the same cycle (combinational from state). Next state is WAIT.
  - When flush_valid: no issue; pc<={flush_pc[XLEN-1:2],2'b00}; stay IDLE.
  - When iq_full and no flush: stay IDLE with no request.
  - imem_resp in IDLE is ignored.
- WAIT:
  - No new request. pc holds the outstanding address.
  - imem_resp && !flush_valid: iq_push=1 in the same cycle, iq_instr=imem_rdata, iq_pc=pc. pc<=pc+4 (wraps mod 2^XLEN). fetch_count<=fetch_count+1 (wraps). Next state IDLE.
  - imem_resp && flush_valid: the response is discarded (iq_push=0). pc<=aligned flush_pc. Next state IDLE.
  - !imem_resp && flush_valid: pc<=aligned flush_pc. Next state DRAIN.
  - Otherwise stay WAIT.
- DRAIN (a stale request is outstanding):
  - Never pushes and never issues.
  - imem_resp: the response is discarded. Next state IDLE; an issue is possible the following cycle.
  - flush_valid (with or without resp): pc<=latest aligned flush_pc. The flush does not extend the drain beyond the pending response.
- Queue space: a request is issued only when !iq_full. Since only this block pushes, the slot is guaranteed at response time, so iq_full is not sampled in WAIT.
- Throughput: at most 1 instruction per 2 cycles (issue, then response). With zero-wait memory (resp the cycle after issue), the pattern is issue, push, issue, push.
- Latency: a push occurs in the same cycle as imem_resp. A redirect takes effect on the first IDLE cycle after the flush (or after the drain).
- busy=1 exactly when state is WAIT or DRAIN.
- Mid-operation reset: from any state, return to IDLE with pc=RESET_PC. The memory is reset alongside this block. Any later stray resp arrives in IDLE and is ignored.

Test Plan:
- Reset then zero-wait memory, iq_full=0: requests at addresses 1eceb000, 1eceb004, 1eceb008 on alternate cycles. Each push carries matching iq_pc/iq_instr; fetch_count=3 after 3 responses.
- 3-cycle memory latency with iq_full asserted after the first push: exactly one push, then no imem_rmask while full. Issue of 1eceb004 resumes the cycle after iq_full drops.
- flush_valid (flush_pc=0x00001003) in WAIT, resp 2 cycles later: the response is dropped (iq_push=0) and busy stays 1 until resp. The next request is to 0x00001000; fetch_count unchanged.
- flush_valid coincident with imem_resp in WAIT (flush_pc=0x2000): no push; next request to 0x2000 on the following cycle.
- Two flushes in DRAIN (0x3000 then 0x4000), then resp: the single stale response is dropped and the next request is to 0x4000.
- rst asserted in WAIT, then a stray resp the cycle after reset release: no push; next request to 1eceb000; fetch_count=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, keeps at most one read
// outstanding on the imem port, pushes each returned instruction with its PC
// into the instruction queue, and redirects on a backend flush while dropping
// any response that was already in flight when the flush arrived.
module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h1eceb000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    output logic [3:0]      imem_rmask,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_resp,
    input  logic            iq_full,
    output logic            iq_push,
    output logic [XLEN-1:0] iq_instr,
    output logic [XLEN-1:0] iq_pc,
    input  logic            flush_valid,
    input  logic [XLEN-1:0] flush_pc,
    output logic            busy,
    output logic [31:0]     fetch_count
);

    // IDLE: free to issue; WAIT: live request outstanding;
    // DRAIN: a request made before a flush is still outstanding.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_fetch_count;

    logic [XLEN-1:0] w_flush_pc_al;
    logic            w_issue;
    logic            w_push;

    // Redirect targets are forced to word alignment.
    assign w_flush_pc_al = {flush_pc[XLEN-1:2], 2'b00};

    // Issue and push are same-cycle strobes derived from the current state;
    // a flush in the same cycle suppresses both.
    assign w_issue = (r_state == S_IDLE) && !flush_valid && !iq_full && !rst;
    assign w_push  = (r_state == S_WAIT) && imem_resp && !flush_valid && !rst;

    assign imem_addr   = r_pc;
    assign imem_rmask  = w_issue ? 4'hf : 4'h0;
    assign iq_push     = w_push;
    assign iq_instr    = imem_rdata;
    assign iq_pc       = r_pc;
    assign busy        = (r_state != S_IDLE) && !rst;
    assign fetch_count = r_fetch_count;

    // Fetch state machine: state, PC and pushed-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_fetch_count <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Responses arriving here are strays and are ignored.
                    if (flush_valid) begin
                        r_pc <= w_flush_pc_al;
                    end else if (!iq_full) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp) begin
                        if (flush_valid) begin
                            r_pc <= w_flush_pc_al;
                        end else begin
                            r_pc          <= r_pc + XLEN'(4);
                            r_fetch_count <= r_fetch_count + 32'd1;
                        end
                        r_state <= S_IDLE;
                    end else if (flush_valid) begin
                        // The old request must still be absorbed before reissue.
                        r_pc    <= w_flush_pc_al;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Later flushes only retarget; the drain ends on the one
                    // pending response regardless.
                    if (flush_valid) begin
                        r_pc <= w_flush_pc_al;
                    end
                    if (imem_resp) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
